// File: rtl/display_pkg.sv
// Shared constants and types for the raster timing generator.
package display_pkg;

   // VGA 640x480@60 horizontal timing, in pixels
   localparam int VGA_H_D  = 640;
   localparam int VGA_H_FP = 16;
   localparam int VGA_H_SP = 96;
   localparam int VGA_H_BP = 48;

   // VGA 640x480@60 vertical timing, in lines
   localparam int VGA_V_D  = 480;
   localparam int VGA_V_FP = 10;
   localparam int VGA_V_SP = 2;
   localparam int VGA_V_BP = 33;

   localparam int VGA_H_TOTAL = VGA_H_D + VGA_H_FP + VGA_H_SP + VGA_H_BP;
   localparam int VGA_V_TOTAL = VGA_V_D + VGA_V_FP + VGA_V_SP + VGA_V_BP;

   // Active level of a sync output
   localparam bit SYNC_ACTIVE_LOW  = 1'b0;
   localparam bit SYNC_ACTIVE_HIGH = 1'b1;

   // Single-bit timing outputs, registered together
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic de;
      logic video_active;
      logic line_start;
      logic frame_start;
   } disp_flags_t;

   // True when lo <= v < hi; an empty span (hi <= lo) never matches
   function automatic logic in_span(input int v, input int lo, input int hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/display_timing_gen_if.sv
// Video timing bundle from the timing generator to the renderer.
interface display_timing_gen_if #(
   parameter int CW = 10
);
   logic          pix_ce;
   logic          hsync;
   logic          vsync;
   logic          de;
   logic          video_active;
   logic [CW-1:0] pixel_x;
   logic [CW-1:0] pixel_y;
   logic [CW-1:0] win_x;
   logic          line_start;
   logic          frame_start;

   modport master (
      output pix_ce, hsync, vsync, de, video_active,
             pixel_x, pixel_y, win_x, line_start, frame_start
   );

   modport slave (
      input  pix_ce, hsync, vsync, de, video_active,
             pixel_x, pixel_y, win_x, line_start, frame_start
   );
endinterface

// File: rtl/display_pixel_ce.sv
// Pixel clock-enable: one-cycle tick every CLK_DIV system clocks.
module display_pixel_ce #(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic reset,
   output logic pix_ce
);

   localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q;
   logic [DW-1:0] div_d;

   // Next divider value: count 0..CLK_DIV-1 and wrap
   always_comb begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
   end

   // Divider register
   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values; async reset clears it without waiting for a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   // With CLK_DIV=1 the divider stays at 0 and the tick is permanently high
   assign pix_ce = (div_q == DIV_LAST);

endmodule

// File: rtl/display_timing_gen.sv
// Parametrised raster timing generator: counters, sync/enable decode and
// start strobes, all registered and decoded from the next counter values.
module display_timing_gen
   import display_pkg::*;
#(
   parameter int H_D     = VGA_H_D,
   parameter int H_FP    = VGA_H_FP,
   parameter int H_SP    = VGA_H_SP,
   parameter int H_BP    = VGA_H_BP,
   parameter int V_D     = VGA_V_D,
   parameter int V_FP    = VGA_V_FP,
   parameter int V_SP    = VGA_V_SP,
   parameter int V_BP    = VGA_V_BP,
   parameter bit HS_POL  = SYNC_ACTIVE_LOW,
   parameter bit VS_POL  = SYNC_ACTIVE_LOW,
   parameter int WIN_X0  = 80,
   parameter int WIN_X1  = 560,
   parameter int CLK_DIV = 1,
   parameter int CW      = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   display_timing_gen_if.master vid
);

   localparam int            H_TOTAL = H_D + H_FP + H_SP + H_BP;
   localparam int            V_TOTAL = V_D + V_FP + V_SP + V_BP;
   localparam logic [CW-1:0] X_LAST  = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] Y_LAST  = CW'(V_TOTAL - 1);

   localparam disp_flags_t FLAGS_RST = '{
      hsync:        ~HS_POL,
      vsync:        ~VS_POL,
      de:           1'b0,
      video_active: 1'b0,
      line_start:   1'b0,
      frame_start:  1'b0
   };

   logic          pix_ce;
   logic [CW-1:0] x_q, x_d;
   logic [CW-1:0] y_q, y_d;
   logic [CW-1:0] win_x_q, win_x_d;
   disp_flags_t   flags_q, flags_d;

   display_pixel_ce #(
      .CLK_DIV (CLK_DIV)
   ) u_pixel_ce (
      .clk    (clk),
      .reset  (reset),
      .pix_ce (pix_ce)
   );

   // Next position: advance one pixel per tick, wrapping x then y together
   // NOTE: defaults first so every path assigns x_d/y_d and no latch is inferred.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (pix_ce) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   // Decode every output from the next position so it lines up with pixel_x/y
   always_comb begin
      int   x_i;
      int   y_i;
      logic de_n;
      logic va_n;
      x_i  = int'(x_d);
      y_i  = int'(y_d);
      de_n = (x_i < H_D) && (y_i < V_D);
      va_n = de_n && in_span(x_i, WIN_X0, WIN_X1);

      flags_d.hsync        = in_span(x_i, H_D + H_FP, H_D + H_FP + H_SP) ? HS_POL : ~HS_POL;
      flags_d.vsync        = in_span(y_i, V_D + V_FP, V_D + V_FP + V_SP) ? VS_POL : ~VS_POL;
      flags_d.de           = de_n;
      flags_d.video_active = va_n;
      // Strobes fire only on the tick that lands on column 0, else they clear
      flags_d.line_start   = pix_ce && (x_d == '0);
      flags_d.frame_start  = pix_ce && (x_d == '0) && (y_d == '0);
      win_x_d              = va_n ? CW'(x_i - WIN_X0) : '0;
   end

   // Position and decoded-output registers; reset parks on the last pixel so
   // the first tick presents (0,0) with both strobes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q     <= X_LAST;
         y_q     <= Y_LAST;
         win_x_q <= '0;
         flags_q <= FLAGS_RST;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         win_x_q <= win_x_d;
         flags_q <= flags_d;
      end
   end

   assign vid.pix_ce       = pix_ce;
   assign vid.hsync        = flags_q.hsync;
   assign vid.vsync        = flags_q.vsync;
   assign vid.de           = flags_q.de;
   assign vid.video_active = flags_q.video_active;
   assign vid.pixel_x      = x_q;
   assign vid.pixel_y      = y_q;
   assign vid.win_x        = win_x_q;
   assign vid.line_start   = flags_q.line_start;
   assign vid.frame_start  = flags_q.frame_start;

endmodule
